// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline memory requests into word-wide memory accesses.
// Sub-word stores are done as a read-modify-write of the containing word.
module load_store_unit #(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);
    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        READ,
        LOAD_DATA,
        RMW_READ,
        RMW_MERGE
    } state_t;

    state_t      state;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic        cap_we;

    logic        fault_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Request legality: illegal size, misalignment or out-of-range address
    always_comb begin
        fault_c = 1'b0;
        case (req_size)
            SIZE_HALF: fault_c = req_addr[0];
            SIZE_WORD: fault_c = (req_addr[1:0] != 2'b00);
            SIZE_BYTE: fault_c = 1'b0;
            default:   fault_c = 1'b1;
        endcase
        if (req_addr >= MEM_LIMIT) begin
            fault_c = 1'b1;
        end
    end

    // Little-endian lane extraction and extension for loads
    always_comb begin
        lane_byte = mem_read_data[{cap_addr[1:0], 3'b000} +: 8];
        lane_half = mem_read_data[{cap_addr[1], 4'b0000} +: 16];
        case (cap_size)
            SIZE_BYTE: load_c = {{24{cap_signed & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_c = {{16{cap_signed & lane_half[15]}}, lane_half};
            default:   load_c = mem_read_data;
        endcase
    end

    // Replace the addressed lane of the fetched word with the store data
    always_comb begin
        merge_c = mem_read_data;
        if (cap_size == SIZE_BYTE) begin
            merge_c[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
        end else begin
            merge_c[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
        end
    end

    assign req_ready      = (state == IDLE);
    assign mem_read_addr  = {cap_addr[31:2], 2'b00};
    assign mem_write_addr = {cap_addr[31:2], 2'b00};
    assign mem_write_data = (state == RMW_MERGE) ? merge_c : cap_wdata;
    // Gated by reset so an abandoned operation can never write
    assign mem_write_en   = !reset && cap_we && ((state == STORE) || (state == RMW_MERGE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            cap_size   <= 2'b00;
            cap_signed <= 1'b0;
            cap_we     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        cap_size   <= req_size;
                        cap_signed <= req_signed;
                        cap_we     <= req_we;
                        if (fault_c) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (!req_we) begin
                            state <= READ;
                        end else if (req_size == SIZE_WORD) begin
                            state <= STORE;
                        end else begin
                            state <= RMW_READ;
                        end
                    end
                end
                STORE, RMW_MERGE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    state      <= IDLE;
                end
                READ:     state <= LOAD_DATA;
                RMW_READ: state <= RMW_MERGE;
                LOAD_DATA: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_c;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide data memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int rv_count = 0;

    load_store_unit #(.MEM_SIZE(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data valid one cycle after the address
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr[11:2]] <= mem_write_data;
        mem_read_data <= mem[mem_read_addr[11:2]];
    end

    always @(negedge clk) begin
        if (mem_write_en) wr_count++;
        if (resp_valid) rv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_fault);
        int lat;
        int wr0;
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        wr0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " fault"}, 32'(resp_fault), 32'(exp_fault));
        if (exp_fault) check({tag, " no write"}, 32'(wr_count - wr0), 32'd0);
    endtask

    task automatic back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exps [3];
        int resp_cyc [3];
        int nacc = 0;
        int nresp = 0;
        int cyc = 0;
        logic rdy;
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h30;
        exps[0] = 32'h80013344; exps[1] = 32'hCD000000; exps[2] = 32'h55667788;
        resp_cyc[0] = 0; resp_cyc[1] = 0; resp_cyc[2] = 0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_wdata = 32'h0;
        req_addr = addrs[0];
        req_valid = 1'b1;
        while (nresp < 3 && cyc < 40) begin
            rdy = req_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && req_valid) begin
                nacc++;
                if (nacc < 3) req_addr = addrs[nacc];
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                check($sformatf("b2b data %0d", nresp), resp_rdata, exps[nresp]);
                resp_cyc[nresp] = cyc;
                nresp++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b responses", 32'(nresp), 32'd3);
        check("b2b first", 32'(resp_cyc[0]), 32'd3);
        check("b2b gap 1", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
        check("b2b gap 2", 32'(resp_cyc[2] - resp_cyc[1]), 32'd3);
    endtask

    initial begin
        int wr0;
        int rv0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_fault", 32'(resp_fault), 32'd0);
        check("reset write_en", 32'(mem_write_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready after reset", 32'(req_ready), 32'd1);

        // Word store then load
        do_req("st word",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        check("mem word", mem[4], 32'hDEADBEEF);
        do_req("ld word",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

        // Byte read-modify-write and extension
        do_req("st word2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0);
        do_req("st byte",  1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 3, 32'h0, 1'b0);
        check("mem byte merge", mem[4], 32'h1122AB44);
        do_req("ld sbyte", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 3, 32'hFFFFFFAB, 1'b0);
        do_req("ld ubyte", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 3, 32'h000000AB, 1'b0);

        // Halfword read-modify-write
        do_req("st word3", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0);
        do_req("st half",  1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 3, 32'h0, 1'b0);
        check("mem half merge", mem[4], 32'h80013344);
        do_req("ld shalf", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 3, 32'hFFFF8001, 1'b0);
        do_req("ld uhalf", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 3, 32'h00003344, 1'b0);

        // Top byte lane, upper store bits must be ignored
        do_req("st word4", 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, 2, 32'h0, 1'b0);
        do_req("st byte3", 1'b1, 2'b00, 1'b0, 32'h23, 32'h123456CD, 3, 32'h0, 1'b0);
        check("mem byte3 merge", mem[8], 32'hCD000000);
        do_req("ld sbyte3", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 3, 32'hFFFFFFCD, 1'b0);

        // Last legal word
        do_req("st last", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0BADF00D, 2, 32'h0, 1'b0);
        do_req("ld last", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 3, 32'h0BADF00D, 1'b0);

        // Faults
        do_req("flt word mis",  1'b0, 2'b10, 1'b0, 32'h13,   32'h0, 1, 32'h0, 1'b1);
        do_req("flt half mis",  1'b1, 2'b01, 1'b0, 32'h21,   32'h5555, 1, 32'h0, 1'b1);
        do_req("flt range",     1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 32'h0, 1'b1);
        do_req("flt size",      1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 1, 32'h0, 1'b1);
        check("fault mem kept", mem[8], 32'hCD000000);

        // Reset while in RMW_READ abandons the store
        do_req("st word5", 1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788, 2, 32'h0, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h31; req_wdata = 32'h99;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wr0 = wr_count;
        rv0 = rv_count;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst ready", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rst no write", 32'(wr_count - wr0), 32'd0);
        check("rst no resp", 32'(rv_count - rv0), 32'd0);
        check("rst mem kept", mem[12], 32'h55667788);
        check("rst fault", 32'(resp_fault), 32'd0);

        back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
